// File: rtl/calc_pkg.sv
// Shared encodings for the calc1 single-port responder and its ALU.
// Command and response fields use MSB-first [0:N-1] ordering.
package calc_pkg;

   localparam logic [0:3] CMD_NOP = 4'd0;
   localparam logic [0:3] CMD_ADD = 4'd1;
   localparam logic [0:3] CMD_SUB = 4'd2;
   localparam logic [0:3] CMD_SHL = 4'd5;
   localparam logic [0:3] CMD_SHR = 4'd6;

   localparam logic [0:1] RESP_NONE = 2'd0;
   localparam logic [0:1] RESP_OK   = 2'd1;
   localparam logic [0:1] RESP_ERR  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GET_OP2,
      ST_EXEC,
      ST_RESP
   } calc_state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational calc1 arithmetic: unsigned add/sub with range errors,
// logical shifts by the low 5 bits of op2, and invalid-command rejection.
module calc_alu
   import calc_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [0:3]        cmd,
   input  logic [0:DATA_W-1] op1,
   input  logic [0:DATA_W-1] op2,
   output logic [0:1]        resp,
   output logic [0:DATA_W-1] data
);

   logic [0:DATA_W] sum;
   logic [0:4]      shamt;

   always_comb begin
      sum   = {1'b0, op1} + {1'b0, op2};
      shamt = op2[DATA_W-5:DATA_W-1];
      resp  = RESP_ERR;
      data  = '0;
      case (cmd)
         CMD_ADD: begin
            // sum[0] is the carry-out of the widened add
            if (!sum[0]) begin
               resp = RESP_OK;
               data = sum[1:DATA_W];
            end
         end
         CMD_SUB: begin
            if (op2 <= op1) begin
               resp = RESP_OK;
               data = op1 - op2;
            end
         end
         CMD_SHL: begin
            resp = RESP_OK;
            data = op1 << shamt;
         end
         CMD_SHR: begin
            resp = RESP_OK;
            data = op1 >> shamt;
         end
         default: begin
            resp = RESP_ERR;
            data = '0;
         end
      endcase
   end

endmodule

// File: rtl/calc_port_responder.sv
// Single-port calc1 responder: two-cycle operand capture, fixed-latency
// execute through calc_alu, one-cycle registered response.
//
// state      | meaning
// IDLE       | waiting for a nonzero command with operand 1
// GET_OP2    | capturing operand 2, loading latency counter
// EXEC       | counting down; result registered when counter hits 0
// RESP       | response valid for this single cycle
module calc_port_responder
   import calc_pkg::*;
#(
   parameter int LATENCY = 3,
   parameter int DATA_W  = 32
) (
   input  logic              c_clk,
   input  logic              reset,
   input  logic [0:3]        req_cmd_in,
   input  logic [0:DATA_W-1] req_data_in,
   output logic [0:1]        out_resp,
   output logic [0:DATA_W-1] out_data,
   output logic              busy
);

   calc_state_t       state_q, state_d;
   logic [0:3]        cmd_q;
   logic [0:DATA_W-1] op1_q;
   logic [0:DATA_W-1] op2_q;
   logic [3:0]        cnt_q;
   logic [0:1]        alu_resp;
   logic [0:DATA_W-1] alu_data;

   calc_alu #(.DATA_W(DATA_W)) u_alu (
      .cmd  (cmd_q),
      .op1  (op1_q),
      .op2  (op2_q),
      .resp (alu_resp),
      .data (alu_data)
   );

   always_ff @(posedge c_clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (req_cmd_in != CMD_NOP) state_d = ST_GET_OP2;
         ST_GET_OP2: state_d = ST_EXEC;
         ST_EXEC:    if (cnt_q == 4'd0) state_d = ST_RESP;
         ST_RESP:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge c_clk) begin
      if (reset) begin
         cmd_q    <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         cnt_q    <= '0;
         out_resp <= RESP_NONE;
         out_data <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_cmd_in != CMD_NOP) begin
                  cmd_q <= req_cmd_in;
                  op1_q <= req_data_in;
               end
            end
            ST_GET_OP2: begin
               op2_q <= req_data_in;
               cnt_q <= 4'(LATENCY - 1);
            end
            ST_EXEC: begin
               if (cnt_q == 4'd0) begin
                  out_resp <= alu_resp;
                  out_data <= alu_data;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               out_resp <= RESP_NONE;
               out_data <= '0;
            end
            default: begin
               out_resp <= RESP_NONE;
               out_data <= '0;
            end
         endcase
      end
   end

   // Commands arriving while busy are dropped simply because only IDLE
   // looks at req_cmd_in.
   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_calc_port_responder.sv
// Scoreboard bench for calc_port_responder: directed commands push expected
// responses (with expected arrival edge); a negedge monitor pops and checks.
module tb_calc_port_responder;

   localparam int LAT = 3;

   logic        c_clk = 1'b0;
   logic        reset = 1'b1;
   logic [0:3]  req_cmd_in = '0;
   logic [0:31] req_data_in = '0;
   logic [0:1]  out_resp;
   logic [0:31] out_data;
   logic        busy;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
      int          edge_no;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   edge_cnt = 0;

   calc_port_responder #(.LATENCY(LAT), .DATA_W(32)) dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .busy        (busy)
   );

   always #5 c_clk = ~c_clk;

   always @(posedge c_clk) edge_cnt <= edge_cnt + 1;

   // Monitor: every nonzero response must match the queue head at the
   // expected edge; idle cycles must carry zero data.
   always @(negedge c_clk) begin
      if (!reset) begin
         if (out_resp != 2'd0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_resp: got resp=%0d data=%08h at edge %0d, required no response",
                        out_resp, out_data, edge_cnt);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (out_resp != e.resp || out_data != e.data || edge_cnt != e.edge_no) begin
                  n_err++;
                  $display("FAIL resp_check: got resp=%0d data=%08h edge=%0d, required resp=%0d data=%08h edge=%0d",
                           out_resp, out_data, edge_cnt, e.resp, e.data, e.edge_no);
               end
            end
         end else begin
            n_cmp++;
            if (out_data != 32'd0) begin
               n_err++;
               $display("FAIL idle_data: got data=%08h with resp 0, required 00000000", out_data);
            end
         end
      end
   end

   task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %08h, required %08h", name, got, want);
      end
   endtask

   // Drives cmd+op1 for the next edge, op2 for the one after; returns just
   // after the op2 edge. want_resp=1 pushes an expectation.
   task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input bit want_resp, input logic [1:0] er, input logic [31:0] ed);
      exp_t e;
      @(posedge c_clk); #1;
      check_now("busy_before_cmd", {31'd0, busy}, 32'd0);
      req_cmd_in  = cmd;
      req_data_in = a;
      if (want_resp) begin
         e.resp    = er;
         e.data    = ed;
         e.edge_no = edge_cnt + 2 + LAT;
         exp_q.push_back(e);
      end
      @(posedge c_clk); #1;
      check_now("busy_after_accept", {31'd0, busy}, 32'd1);
      req_cmd_in  = 4'd0;
      req_data_in = b;
      @(posedge c_clk); #1;
      req_data_in = 32'd0;
   endtask

   task automatic op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] er, input logic [31:0] ed);
      issue(cmd, a, b, 1'b1, er, ed);
      // Minimum legal spacing: next command sampled at edge N+3+LAT
      repeat (LAT) @(posedge c_clk);
   endtask

   initial begin
      repeat (3) @(posedge c_clk);
      #1;
      reset = 1'b0;
      check_now("reset_resp", {30'd0, out_resp}, 32'd0);
      check_now("reset_data", out_data, 32'd0);
      check_now("reset_busy", {31'd0, busy}, 32'd0);

      op(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000);
      op(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000);
      op(4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE);
      op(4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000);
      op(4'd2, 32'h0000_000F, 32'h0000_0001, 2'd1, 32'h0000_000E);
      op(4'd5, 32'h0000_0001, 32'h0000_0004, 2'd1, 32'h0000_0010);
      op(4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001);
      op(4'd3, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0000_0000);
      op(4'd4, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0000_0000);
      op(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000);
      op(4'd1, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000);
      op(4'd1, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF);
      op(4'd2, 32'h1234_5678, 32'h1234_5678, 2'd1, 32'h0000_0000);
      op(4'd5, 32'hA5A5_A5A5, 32'h0000_0000, 2'd1, 32'hA5A5_A5A5);
      op(4'd5, 32'h0000_0001, 32'h0000_001F, 2'd1, 32'h8000_0000);
      op(4'd5, 32'h0000_0001, 32'hFFFF_FFE4, 2'd1, 32'h0000_0010);
      op(4'd6, 32'hF000_0000, 32'h0000_0004, 2'd1, 32'h0F00_0000);

      // Busy drop: subtract issued two cycles after add is ignored
      issue(4'd1, 32'h0000_0010, 32'h0000_0020, 1'b1, 2'd1, 32'h0000_0030);
      @(posedge c_clk); #1;
      req_cmd_in  = 4'd2;
      req_data_in = 32'h0000_0005;
      @(posedge c_clk); #1;
      req_cmd_in  = 4'd0;
      req_data_in = 32'h0000_0001;
      @(posedge c_clk); #1;
      req_data_in = 32'h0;
      repeat (LAT + 4) @(posedge c_clk);

      // Reset during EXEC aborts the operation silently
      issue(4'd1, 32'h0000_0007, 32'h0000_0008, 1'b0, 2'd0, 32'h0);
      reset = 1'b1;
      @(posedge c_clk); #1;
      reset = 1'b0;
      check_now("midreset_resp", {30'd0, out_resp}, 32'd0);
      check_now("midreset_busy", {31'd0, busy}, 32'd0);
      repeat (LAT + 4) @(posedge c_clk);
      op(4'd1, 32'h0000_0007, 32'h0000_0008, 2'd1, 32'h0000_000F);

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge c_clk);
      repeat (4) @(posedge c_clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
